// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// muldiv_pkg : shared encodings for the RV32M multiply/divide sequencer
// Rev 1.0
// ============================================================================
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic op_a_signed(input logic [2:0] funct3);
    return (funct3 != OP_MULHU) && (funct3 != OP_DIVU) && (funct3 != OP_REMU);
  endfunction

  // MULHSU treats rs2 as unsigned
  function automatic logic op_b_signed(input logic [2:0] funct3);
    return (funct3 == OP_MUL) || (funct3 == OP_MULH) ||
           (funct3 == OP_DIV) || (funct3 == OP_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// muldiv_if : EX-stage handshake between the pipeline and the M-unit
// Rev 1.0
// ============================================================================
interface muldiv_if;

  logic                         start_i;
  logic [2:0]                   funct3_i;
  logic [muldiv_pkg::XLEN-1:0]  a_i;
  logic [muldiv_pkg::XLEN-1:0]  b_i;
  logic                         flush_i;
  logic                         stall_o;
  logic                         busy_o;
  logic                         done_o;
  logic [muldiv_pkg::XLEN-1:0]  result_o;

  modport master (
    output start_i, funct3_i, a_i, b_i, flush_i,
    input  stall_o, busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, funct3_i, a_i, b_i, flush_i,
    output stall_o, busy_o, done_o, result_o
  );

endinterface
`default_nettype wire

// File: rtl/muldiv_iter_dp.sv
`default_nettype none
// ============================================================================
// muldiv_iter_dp : unsigned shift-add multiply / restoring divide, one bit per step
// Rev 1.0
// ============================================================================
module muldiv_iter_dp
  import muldiv_pkg::*;
(
  input  wire                  clk,
  input  wire                  rst_n,
  input  wire                  i_load,
  input  wire                  i_step,
  input  wire [XLEN-1:0]       i_a_mag,
  input  wire [XLEN-1:0]       i_b_mag,
  output logic [2*XLEN-1:0]    o_prod_next,
  output logic [XLEN-1:0]      o_quot_next,
  output logic [XLEN-1:0]      o_rem_next
);

  logic [2*XLEN-1:0] r_prod;
  logic [XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]   r_quot;
  logic [XLEN-1:0]   r_divisor;
  logic [XLEN:0]     r_rem;

  logic [XLEN:0]     w_sum;
  logic [XLEN+1:0]   w_trial;
  logic              w_fits;
  logic [XLEN:0]     w_diff;
  logic [XLEN:0]     w_rem_next;
  logic [XLEN-1:0]   w_quot_next;

  // Low half of r_prod starts as the multiplier and is consumed LSB first
  always_comb begin
    w_sum       = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    w_trial     = {r_rem, r_quot[XLEN-1]};
    w_fits      = (w_trial >= {2'b00, r_divisor});
    w_diff      = w_trial[XLEN:0] - {1'b0, r_divisor};
    w_rem_next  = w_fits ? w_diff : w_trial[XLEN:0];
    w_quot_next = {r_quot[XLEN-2:0], w_fits};
    o_prod_next = {w_sum, r_prod[XLEN-1:1]};
    o_quot_next = w_quot_next;
    o_rem_next  = w_rem_next[XLEN-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod    <= '0;
      r_mcand   <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
      r_rem     <= '0;
    end else if (i_load) begin
      r_prod    <= {{XLEN{1'b0}}, i_b_mag};
      r_mcand   <= i_a_mag;
      r_quot    <= i_a_mag;
      r_divisor <= i_b_mag;
      r_rem     <= '0;
    end else if (i_step) begin
      r_prod    <= o_prod_next;
      r_quot    <= w_quot_next;
      r_rem     <= w_rem_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// muldiv_sequencer : RV32M multi-cycle controller with sign fix-up (EX stage)
// Rev 1.0
// ============================================================================
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  wire       clk,
  input  wire       rst_n,
  muldiv_if.slave   bus
);

  state_t            r_state;
  logic [4:0]        r_cnt;
  logic [2:0]        r_op;
  logic              r_sign_a;
  logic              r_sign_b;
  logic              r_done;
  logic              r_busy;
  logic [XLEN-1:0]   r_result;

  logic              w_accept;
  logic              w_div_by_zero;
  logic              w_load;
  logic              w_step;
  logic              w_sign_a;
  logic              w_sign_b;
  logic              w_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN-1:0]   w_quot_next;
  logic [XLEN-1:0]   w_rem_next;
  logic [XLEN-1:0]   w_final;
  logic [2*XLEN-1:0] w_prod_next;
  logic [2*XLEN-1:0] w_prod_fix;

  always_comb begin
    w_accept      = (r_state == ST_IDLE) && bus.start_i && !bus.flush_i;
    w_div_by_zero = w_accept && bus.funct3_i[2] && (bus.b_i == '0);
    w_load        = w_accept && !w_div_by_zero;
    w_step        = (r_state == ST_BUSY);
    w_sign_a      = op_a_signed(bus.funct3_i) && bus.a_i[XLEN-1];
    w_sign_b      = op_b_signed(bus.funct3_i) && bus.b_i[XLEN-1];
    w_a_mag       = w_sign_a ? -bus.a_i : bus.a_i;
    w_b_mag       = w_sign_b ? -bus.b_i : bus.b_i;
    w_neg         = r_sign_a ^ r_sign_b;
    w_prod_fix    = w_neg ? -w_prod_next : w_prod_next;
    w_final       = '0;
    // Remainder follows the dividend sign; everything else follows sign parity
    case (r_op)
      OP_MUL:                       w_final = w_prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_final = w_neg ? -w_quot_next : w_quot_next;
      OP_REM, OP_REMU:              w_final = r_sign_a ? -w_rem_next : w_rem_next;
      default:                      w_final = '0;
    endcase
  end

  muldiv_iter_dp u_iter_dp (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_step      (w_step),
    .i_a_mag     (w_a_mag),
    .i_b_mag     (w_b_mag),
    .o_prod_next (w_prod_next),
    .o_quot_next (w_quot_next),
    .o_rem_next  (w_rem_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if (bus.flush_i) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_div_by_zero) begin
              r_state  <= ST_DONE;
              r_done   <= 1'b1;
              r_result <= bus.funct3_i[1] ? bus.a_i : '1;
            end else if (w_load) begin
              r_state  <= ST_BUSY;
              r_busy   <= 1'b1;
              r_cnt    <= '0;
              r_op     <= bus.funct3_i;
              r_sign_a <= w_sign_a;
              r_sign_b <= w_sign_b;
            end
          end
          ST_BUSY: begin
            if (r_cnt == 5'd31) begin
              r_state  <= ST_DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_result <= w_final;
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.stall_o  = w_accept || w_step;
  assign bus.busy_o   = r_busy;
  assign bus.done_o   = r_done;
  assign bus.result_o = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// tb_muldiv_sequencer : scoreboard bench with an arithmetic reference model
// Rev 1.0
// ============================================================================
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  logic   clk;
  logic   rst_n;
  int     cyc;
  int     checks;
  int     errors;
  bit     mon_en;
  logic [31:0] exp_last;
  exp_t   exp_q[$];

  muldiv_if bus ();

  muldiv_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Plain integer arithmetic, RISC-V rules for the divide corner cases
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ub;
    logic [63:0] p;
    logic        ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (f)
      OP_MUL:    begin p = sa * sb; return p[31:0]; end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:    return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom());
    endcase
  endfunction

  task automatic idle_inputs();
    bus.start_i  = 1'b0;
    bus.flush_i  = 1'b0;
    bus.funct3_i = 3'd0;
    bus.a_i      = 32'd0;
    bus.b_i      = 32'd0;
  endtask

  // Called just after a rising edge with the DUT in IDLE; start stays high through DONE
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int   lat;
    bit   seen;
    exp_t e;
    bus.start_i  = 1'b1;
    bus.flush_i  = 1'b0;
    bus.funct3_i = f;
    bus.a_i      = a;
    bus.b_i      = b;
    lat   = (f[2] && b == 0) ? 1 : 33;
    e.res = ref_model(f, a, b);
    e.due = cyc + lat;
    exp_q.push_back(e);
    @(negedge clk);
    check("stall_accept", 32'(bus.stall_o), 32'd1);
    check("busy_accept", 32'(bus.busy_o), 32'd0);
    seen = 1'b0;
    for (int k = 1; k <= lat + 6 && !seen; k++) begin
      @(negedge clk);
      if (bus.done_o) begin
        seen = 1'b1;
        check("stall_done", 32'(bus.stall_o), 32'd0);
        check("busy_done", 32'(bus.busy_o), 32'd0);
      end else begin
        check("stall_busy", 32'(bus.stall_o), 32'd1);
        check("busy_busy", 32'(bus.busy_o), 32'd1);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done op=%0d", f);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && mon_en) begin
        if (bus.done_o) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done_unexpected actual=done result=%h required=no_done", bus.result_o);
          end else begin
            e = exp_q.pop_front();
            check("result", bus.result_o, e.res);
            check("done_cycle", 32'(cyc), 32'(e.due));
            exp_last = e.res;
          end
        end else begin
          check("result_hold", bus.result_o, exp_last);
        end
      end
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    mon_en   = 1'b0;
    exp_last = 32'd0;
    rst_n    = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_result", bus.result_o, 32'd0);
    check("rst_done", 32'(bus.done_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_stall", 32'(bus.stall_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    run_op(OP_MUL,    32'd7,          32'hFFFF_FFFD);
    run_op(OP_MULH,   32'h8000_0000,  32'h8000_0000);
    run_op(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF);
    run_op(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    run_op(OP_DIV,    32'hFFFF_FFF9,  32'd2);
    run_op(OP_REM,    32'hFFFF_FFF9,  32'd2);
    run_op(OP_DIVU,   32'd100,        32'd7);
    run_op(OP_REMU,   32'd100,        32'd7);
    run_op(OP_DIV,    32'd5,          32'd0);
    run_op(OP_REM,    32'd5,          32'd0);
    run_op(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF);
    run_op(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF);

    // Flush at cycle 10 of a divide; no completion may follow
    bus.start_i  = 1'b1;
    bus.funct3_i = OP_DIV;
    bus.a_i      = 32'd1000;
    bus.b_i      = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    check("flush_busy", 32'(bus.busy_o), 32'd0);
    check("flush_stall", 32'(bus.stall_o), 32'd0);
    check("flush_done", 32'(bus.done_o), 32'd0);
    @(posedge clk);
    #1;
    run_op(OP_MUL, 32'd3, 32'd4);

    // Flush and start together in IDLE
    bus.start_i  = 1'b1;
    bus.flush_i  = 1'b1;
    bus.funct3_i = OP_MUL;
    bus.a_i      = 32'd9;
    bus.b_i      = 32'd9;
    @(negedge clk);
    check("flush_start_stall", 32'(bus.stall_o), 32'd0);
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    check("flush_start_busy", 32'(bus.busy_o), 32'd0);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-multiply
    bus.start_i  = 1'b1;
    bus.funct3_i = OP_MUL;
    bus.a_i      = 32'd123;
    bus.b_i      = 32'd456;
    repeat (5) @(posedge clk);
    #2;
    rst_n    = 1'b0;
    exp_last = 32'd0;
    idle_inputs();
    #1;
    check("midrst_result", bus.result_o, 32'd0);
    check("midrst_done", 32'(bus.done_o), 32'd0);
    check("midrst_busy", 32'(bus.busy_o), 32'd0);
    check("midrst_stall", 32'(bus.stall_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_resume", 32'(bus.busy_o), 32'd0);
    @(posedge clk);
    #1;
    run_op(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);

    for (int i = 0; i < 30; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick());
    end

    idle_inputs();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_results actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle controller and iterative datapath for the RV32M multiply/divide instructions in the EX stage of the 5-stage core. It accepts one M-extension operation at a time from EX and stalls the pipeline while it iterates. When the result is ready, it releases the stall for exactly one cycle so EX can forward and advance. Single-cycle ALU operations bypass this block.

## Interface
- XLEN, 32, operand and result width; only 32 is supported.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  EX holds a valid M-extension instruction; held high for as long as EX is stalled.
- funct3_i  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a_i  input  XLEN  rs1 operand (forwarded value).
- b_i  input  XLEN  rs2 operand (forwarded value).
- flush_i  input  1  EX is being flushed (branch or jump redirect); aborts any operation in flight.
- stall_o  output  1  hold IF/ID/EX.
- busy_o  output  1  state is BUSY.
- done_o  output  1  one-cycle pulse; result_o is valid in this cycle.
- result_o  output  XLEN  registered result.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE→BUSY: on start_i && !flush_i. Latch funct3, the operand signs, |a| and |b| (magnitude taken only for signed operands), and clear the counter.
- IDLE→DONE (fast path): on a division/remainder with b_i==0. Required results: DIV/DIVU → 0xFFFFFFFF; REM/REMU → a_i.
- BUSY: 32 iterations, one per cycle, counter 0..31.
  - Multiply: shift-add into a 64-bit product register.
  - Divide: restoring division with a 33-bit partial remainder.
- BUSY→DONE: when counter==31.
  - Apply sign correction and load result_o.
  - Product is negated when the operand signs differ; MULHU and DIVU/REMU are never negated. MULHSU treats b as unsigned.
  - MUL returns the low 32 bits; MULH, MULHSU and MULHU return the high 32 bits.
  - Quotient is negated when the signs differ; remainder takes the sign of the dividend.
  - Overflow −2^31 / −1 is not special-cased. It falls out naturally: quotient 0x80000000, remainder 0.
- DONE→IDLE: unconditional. start_i is ignored in DONE because EX still holds the same instruction.
- start_i is ignored in BUSY and DONE.
- flush_i in any state: next state IDLE, no done_o, result_o unchanged.
- stall_o = (IDLE && start_i && !flush_i) || BUSY. It is 0 in DONE.

## Timing
- Reset (rst_n low, asynchronous): state IDLE; counter, product and remainder registers 0; result_o 0; done_o 0; busy_o 0; stall_o 0.
- Start sampled at cycle 0 (IDLE):
  - Cycles 1–32: BUSY.
  - Cycle 33: DONE, done_o=1, result_o valid.
  - stall_o high in cycles 0–32 inclusive.
- Divide-by-zero: start at cycle 0, DONE at cycle 1; stall_o high in cycle 0 only.
- Back-to-back M instructions: the next instruction reaches EX in the IDLE cycle after DONE and is accepted there. Throughput is one operation per 34 cycles.
- result_o holds its value until the next DONE.
- Reset deasserted mid-operation never resumes; the block always restarts from IDLE.
- flush_i and start_i high together in IDLE: flush wins, no state change, stall_o=0.

## Structure
- Shared package muldiv_pkg:
  - funct3 operation encodings (OP_MUL … OP_REMU).
  - State enum (ST_IDLE, ST_BUSY, ST_DONE).
  - XLEN constant.
- One sub-module, muldiv_iter_dp: holds the product/remainder registers and one iteration step, enabled by the FSM.
- FSM, counter and sign fix-up stay in the top module.

## Test plan
- MUL 7 × −3 → done_o at cycle 33, result 0xFFFFFFEB; stall_o high cycles 0–32, low at 33.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU −1 × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7 / 2 → −3 (0xFFFFFFFD); REM −7 / 2 → −1; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIV 5 / 0 → done at cycle 1, 0xFFFFFFFF; REM 5 / 0 → 5. DIV 0x80000000 / −1 → 0x80000000; REM of the same operands → 0.
- flush_i at cycle 10 of a DIV → IDLE at cycle 11, no done_o, stall_o low, result_o unchanged. A new MUL 3 × 4 started immediately after → 12 at cycle 33 relative to its own start.
- rst_n pulsed low at cycle 5 of a MUL → outputs zero immediately. After release, start_i held high across DONE triggers exactly one done_o per accepted start.
